bcd_countdown_timer: RTL

- Programmable MM:SS countdown timer; upstream source of digit values for the 8-digit segment display driver.
- Holds four packed BCD digits, decrements once per second while running and flags expiry.
- The display stage consumes `bcd_out` and `upd` and maps each nibble to its segment pattern; this block does no segment encoding.

---
 rtl/bcd_countdown_timer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer feeding the segment display driver.
// Holds four packed BCD digits, counts down once per second while running, and flags expiry with an alarm window.
module bcd_countdown_timer #(
  parameter int unsigned CLK_PER_SEC = 50_000_000,
  parameter int unsigned ALARM_SEC   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_p,
  input  logic        pause_p,
  input  logic        load_p,
  input  logic [7:0]  load_min,
  input  logic [7:0]  load_sec,
  output logic [15:0] bcd_out,
  output logic        upd,
  output logic        running,
  output logic        alarm,
  output logic        done_p,
  output logic        load_err,
  output logic [1:0]  dbg_state
);

  // Interface: start_p/pause_p/load_p are single-cycle request pulses sampled on
  // clk with no backpressure; upd/done_p/load_err are single-cycle strobes that
  // the consumer must sample in the cycle they are high.

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);
  localparam logic [7:0]    ALARM_LAST = 8'(ALARM_SEC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_value;
  logic [15:0]   w_value_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic [7:0]    r_alarm_cnt;
  logic [7:0]    w_alarm_cnt_nxt;
  logic [7:0]    w_alarm_inc;
  logic          r_upd;
  logic          w_upd_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic          r_load_err;
  logic          w_load_err_nxt;
  logic          w_tick;
  logic          w_load_ok;
  logic [15:0]   w_load_val;
  logic [15:0]   w_dec;

  // One-second step down with a borrow rippling S0 -> S1 -> M0 -> M1.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    logic       b;
    m1 = v[15:12];
    m0 = v[11:8];
    s1 = v[7:4];
    s0 = v[3:0];
    b  = 1'b1;
    if (s0 == 4'd0) begin
      s0 = 4'd9;
    end else begin
      s0 = s0 - 4'd1;
      b  = 1'b0;
    end
    if (b) begin
      if (s1 == 4'd0) begin
        s1 = 4'd5;
      end else begin
        s1 = s1 - 4'd1;
        b  = 1'b0;
      end
    end
    if (b) begin
      if (m0 == 4'd0) begin
        m0 = 4'd9;
      end else begin
        m0 = m0 - 4'd1;
        b  = 1'b0;
      end
    end
    if (b) begin
      m1 = m1 - 4'd1;
    end
    return {m1, m0, s1, s0};
  endfunction

  assign w_tick      = ((r_state == S_RUN) || (r_state == S_ALARM)) && (r_presc == PRESC_LAST);
  assign w_load_ok   = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                       (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);
  assign w_load_val  = {load_min, load_sec};
  assign w_dec       = bcd_dec(r_value);
  assign w_alarm_inc = r_alarm_cnt + 8'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_value_nxt     = r_value;
    w_presc_nxt     = r_presc;
    w_alarm_cnt_nxt = r_alarm_cnt;
    w_upd_nxt       = 1'b0;
    w_done_nxt      = 1'b0;
    w_load_err_nxt  = 1'b0;

    if ((r_state == S_RUN) || (r_state == S_ALARM)) begin
      w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (load_p) begin
          if (w_load_ok) begin
            w_value_nxt = w_load_val;
            w_upd_nxt   = 1'b1;
          end else begin
            w_load_err_nxt = 1'b1;
          end
        end else if (start_p && (r_value != 16'h0000)) begin
          w_state_nxt = S_RUN;
          w_presc_nxt = '0;
        end
      end

      S_RUN: begin
        // A tick coinciding with pause still lands its decrement first.
        if (w_tick) begin
          w_value_nxt = w_dec;
          w_upd_nxt   = 1'b1;
          if (w_dec == 16'h0000) begin
            w_state_nxt     = S_ALARM;
            w_done_nxt      = 1'b1;
            w_presc_nxt     = '0;
            w_alarm_cnt_nxt = 8'd0;
          end else if (pause_p) begin
            w_state_nxt = S_PAUSE;
          end
        end else if (pause_p) begin
          w_state_nxt = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (load_p) begin
          if (w_load_ok) begin
            w_value_nxt = w_load_val;
            w_upd_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_load_err_nxt = 1'b1;
          end
        end else if (start_p) begin
          w_state_nxt = S_RUN;
        end
      end

      S_ALARM: begin
        // A rejected load consumes the request pulses but not the seconds tick.
        if (load_p && w_load_ok) begin
          w_value_nxt = w_load_val;
          w_upd_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!load_p && (start_p || pause_p)) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          w_alarm_cnt_nxt = w_alarm_inc;
          if (w_alarm_inc == ALARM_LAST) begin
            w_state_nxt = S_IDLE;
          end
        end
        if (load_p && !w_load_ok) begin
          w_load_err_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_value     <= 16'h0000;
      r_presc     <= '0;
      r_alarm_cnt <= 8'd0;
      r_upd       <= 1'b0;
      r_done      <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_value     <= w_value_nxt;
      r_presc     <= w_presc_nxt;
      r_alarm_cnt <= w_alarm_cnt_nxt;
      r_upd       <= w_upd_nxt;
      r_done      <= w_done_nxt;
      r_load_err  <= w_load_err_nxt;
    end
  end

  assign bcd_out   = r_value;
  assign upd       = r_upd;
  assign running   = (r_state == S_RUN);
  assign alarm     = (r_state == S_ALARM);
  assign done_p    = r_done;
  assign load_err  = r_load_err;
  assign dbg_state = r_state;

endmodule
